// File: rtl/eprisc_iobus_master.sv
// eprisc_iobus_master
//   CPU-side initiator for the epRISC byte-wide I/O controller bus. A 32-bit
//   frame word {write, addr[14:0], data[15:0]} is shifted out LSB byte first
//   over six bus-clock beats (Load, LoLo, Lo, Hi, HiHi, Store). MISO bytes
//   are collected during beats 1-4. A read takes two frames because the slave
//   answers with data for the address latched by the previous frame.
//
//   Parameter CLKDIV : system clocks per bus-clock half-period (>= 1).
//
//   Optional feature macro IOBUS_IRQ_LATCH_EN:
//     defined   - iBusInterrupt is synchronised (2 flops) and a rising edge
//                 sets a sticky oIrq, cleared by iIrqAck (set wins).
//     undefined - oIrq is iBusInterrupt registered once; iIrqAck is ignored.
//
//   Ports
//     iBoardClock, iBoardReset   system clock, async active-low reset
//     iReqValid/oReqReady        request handshake (ready only in idle)
//     iReqWrite, iReqTarget, iReqAddr, iReqData   request fields
//     oRespValid, oRespData      one-cycle completion pulse + MISO word
//     oBusClock, oBusSelect, oBusMOSI, iBusMISO   controller bus
//     iBusInterrupt, iIrqAck, oIrq                interrupt path
module eprisc_iobus_master #(
   parameter int CLKDIV = 2
) (
   input  logic        iBoardClock,
   input  logic        iBoardReset,
   input  logic        iReqValid,
   output logic        oReqReady,
   input  logic        iReqWrite,
   input  logic [1:0]  iReqTarget,
   input  logic [14:0] iReqAddr,
   input  logic [15:0] iReqData,
   output logic        oRespValid,
   output logic [31:0] oRespData,
   output logic        oBusClock,
   output logic [1:0]  oBusSelect,
   output logic [7:0]  oBusMOSI,
   input  logic [7:0]  iBusMISO,
   input  logic        iBusInterrupt,
   input  logic        iIrqAck,
   output logic        oIrq
);

   localparam int DW = (CLKDIV > 1) ? $clog2(CLKDIV) : 1;
   localparam logic [DW-1:0] DIV_LAST = DW'(CLKDIV - 1);

   typedef enum logic [1:0] {stSync, stIdle, stFrame, stGap} stateT;

   stateT       state, stateNext;
   logic [DW-1:0] divCnt, divNext;       // cycle within current half-period
   logic [3:0]  halfCnt, halfNext;       // 0 = setup, odd = clock high, even = clock low
   logic        secondFrame, secondNext; // read: currently in the reporting frame
   logic        reqWrite, writeNext;
   logic [1:0]  target, targetNext;
   logic [31:0] frameWord, wordNext;
   logic [31:0] capture, captureNext;

   logic        busClockNext, respValidNext, readyNext;
   logic [1:0]  selectNext;
   logic [7:0]  mosiNext;
   logic [31:0] respDataNext;
   logic        lastDiv;
   logic [3:0]  halfM1;

   always_ff @(posedge iBoardClock or negedge iBoardReset) begin
      if (!iBoardReset) begin
         state       <= stSync;
         divCnt      <= DIV_LAST;   // first edge after release opens the sync high phase
         halfCnt     <= 4'd0;
         secondFrame <= 1'b0;
         reqWrite    <= 1'b0;
         target      <= 2'd0;
         frameWord   <= 32'd0;
         capture     <= 32'd0;
         oBusClock   <= 1'b0;
         oBusSelect  <= 2'd0;
         oBusMOSI    <= 8'd0;
         oReqReady   <= 1'b0;
         oRespValid  <= 1'b0;
         oRespData   <= 32'd0;
      end else begin
         state       <= stateNext;
         divCnt      <= divNext;
         halfCnt     <= halfNext;
         secondFrame <= secondNext;
         reqWrite    <= writeNext;
         target      <= targetNext;
         frameWord   <= wordNext;
         capture     <= captureNext;
         oBusClock   <= busClockNext;
         oBusSelect  <= selectNext;
         oBusMOSI    <= mosiNext;
         oReqReady   <= readyNext;
         oRespValid  <= respValidNext;
         oRespData   <= respDataNext;
      end
   end

   always_comb begin
      stateNext     = state;
      divNext       = divCnt;
      halfNext      = halfCnt;
      secondNext    = secondFrame;
      writeNext     = reqWrite;
      targetNext    = target;
      wordNext      = frameWord;
      captureNext   = capture;
      respValidNext = 1'b0;
      respDataNext  = oRespData;
      lastDiv       = (divCnt == DIV_LAST);

      case (state)
         stSync: begin
            if (lastDiv) begin
               divNext = '0;
               if (halfCnt == 4'd2) stateNext = stIdle;
               else                 halfNext  = halfCnt + 4'd1;
            end else begin
               divNext = divCnt + 1'b1;
            end
         end
         stIdle: begin
            if (iReqValid && oReqReady) begin
               writeNext  = iReqWrite;
               targetNext = iReqTarget;
               wordNext   = {iReqWrite, iReqAddr, iReqWrite ? iReqData : 16'h0000};
               if (iReqTarget == 2'd0) begin
                  // no device on select 0: complete immediately with zero data
                  respValidNext = 1'b1;
                  respDataNext  = 32'd0;
               end else begin
                  stateNext  = stFrame;
                  halfNext   = 4'd0;
                  divNext    = '0;
                  secondNext = 1'b0;
               end
            end
         end
         stFrame: begin
            if (lastDiv) begin
               divNext = '0;
               // edge that drops the clock in beats 1-4 samples the MISO byte
               if (halfCnt[0] && (halfCnt <= 4'd7))
                  captureNext[{halfCnt[2:1], 3'b000} +: 8] = iBusMISO;
               if (halfCnt == 4'd12) begin
                  if (!reqWrite && !secondFrame) begin
                     stateNext = stGap;
                  end else begin
                     stateNext     = stIdle;
                     respValidNext = 1'b1;
                     respDataNext  = captureNext;
                  end
               end else begin
                  halfNext = halfCnt + 4'd1;
               end
            end else begin
               divNext = divCnt + 1'b1;
            end
         end
         stGap: begin
            if (lastDiv) begin
               divNext    = '0;
               halfNext   = 4'd0;
               secondNext = 1'b1;
               stateNext  = stFrame;
            end else begin
               divNext = divCnt + 1'b1;
            end
         end
         default: stateNext = stSync;
      endcase

      // bus outputs are registered versions of the decode of the next state
      busClockNext = 1'b0;
      selectNext   = 2'd0;
      mosiNext     = 8'd0;
      readyNext    = 1'b0;
      halfM1       = halfNext - 4'd1;
      case (stateNext)
         stSync: busClockNext = halfNext[0];
         stIdle: readyNext    = !respValidNext;
         stFrame: begin
            busClockNext = halfNext[0];
            selectNext   = targetNext;
            if (halfNext == 4'd0)
               mosiNext = wordNext[7:0];
            else if (halfNext <= 4'd8)
               mosiNext = wordNext[{halfM1[2:1], 3'b000} +: 8];
         end
         default: ;
      endcase
   end

`ifdef IOBUS_IRQ_LATCH_EN
   logic [2:0] irqSync;   // [1:0] synchroniser, [2] edge-detect history

   always_ff @(posedge iBoardClock or negedge iBoardReset) begin
      if (!iBoardReset) begin
         irqSync <= 3'd0;
         oIrq    <= 1'b0;
      end else begin
         irqSync <= {irqSync[1:0], iBusInterrupt};
         if (irqSync[1] && !irqSync[2]) oIrq <= 1'b1;
         else if (iIrqAck)              oIrq <= 1'b0;
      end
   end
`else
   logic unusedIrqAck;
   assign unusedIrqAck = iIrqAck;

   always_ff @(posedge iBoardClock or negedge iBoardReset) begin
      if (!iBoardReset) oIrq <= 1'b0;
      else              oIrq <= iBusInterrupt;
   end
`endif

endmodule
